cga_text_sequencer: RTL and testbench

Text-mode pixel sequencer that sits downstream of the 6845-style CRTC and consumes its per-character timing outputs. For each character clock it does the following:
- fetches the character and attribute bytes from video RAM;
- looks up the glyph row in the font ROM;
- serializes eight pixels with attribute, blink and cursor applied;
- emits 4-bit IRGB plus re-aligned syncs to the DAC/scan-doubler stage.

It is the read side of the CRTC's memory-address/row-address interface.

---
 rtl/cga_text_sequencer_pkg.sv | 27 ++
 rtl/cga_text_sequencer_if.sv | 25 ++
 rtl/cga_text_sequencer_shifter.sv | 57 +++++
 rtl/cga_text_sequencer.sv | 154 +++++++++++++++
 tb/tb_cga_text_sequencer.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/cga_text_sequencer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cga_text_sequencer_pkg : shared state, attribute fields and timing constants
// Rev 1.0
// ----------------------------------------------------------------------------
package cga_text_sequencer_pkg;

  localparam int c_CHAR_CLKS    = 8;

  localparam int c_ATTR_FG_MSB  = 3;
  localparam int c_ATTR_FG_LSB  = 0;
  localparam int c_ATTR_BG_MSB  = 6;
  localparam int c_ATTR_BG_LSB  = 4;
  localparam int c_ATTR_BLINK   = 7;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CHAR = 3'd1,
    ATTR = 3'd2,
    FONT = 3'd3,
    DONE = 3'd4
  } seq_state_t;

  typedef logic [3:0] irgb_t;

endpackage
`default_nettype wire

// File: rtl/cga_text_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cga_text_sequencer_if : VRAM and font ROM read bus of the text sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
interface cga_text_sequencer_if #(
  parameter int FONT_ROW_BITS = 3
);
  logic [14:0]                 vram_addr;
  logic                        vram_rd;
  logic [7:0]                  vram_data;
  logic [8+FONT_ROW_BITS-1:0]  font_addr;
  logic [7:0]                  font_data;

  modport master (
    output vram_addr, vram_rd, font_addr,
    input  vram_data, font_data
  );

  modport slave (
    input  vram_addr, vram_rd, font_addr,
    output vram_data, font_data
  );
endinterface
`default_nettype wire

// File: rtl/cga_text_sequencer_shifter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// text_pixel_shifter : loads one glyph row and shifts it out MSB first as IRGB
// Rev 1.0
// ----------------------------------------------------------------------------
module text_pixel_shifter
  import cga_text_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] font_byte,
  input  irgb_t      fg,
  input  irgb_t      bg,
  input  irgb_t      border,
  input  logic       force_fg,
  input  logic       force_border,
  output irgb_t      pixel
);

  logic [7:0] r_shift;
  irgb_t      r_fg;
  irgb_t      r_bg;
  irgb_t      w_fg_eff;
  irgb_t      w_bg_eff;

  // Overrides collapse both colours so the glyph bits no longer matter.
  always_comb begin
    w_fg_eff = fg;
    w_bg_eff = bg;
    if (force_border) begin
      w_fg_eff = border;
      w_bg_eff = border;
    end else if (force_fg) begin
      w_bg_eff = fg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_fg    <= '0;
      r_bg    <= '0;
      pixel   <= '0;
    end else if (load) begin
      r_shift <= {font_byte[6:0], 1'b0};
      r_fg    <= w_fg_eff;
      r_bg    <= w_bg_eff;
      pixel   <= font_byte[7] ? w_fg_eff : w_bg_eff;
    end else begin
      r_shift <= {r_shift[6:0], 1'b0};
      pixel   <= r_shift[7] ? r_fg : r_bg;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cga_text_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cga_text_sequencer : per-cell VRAM/font fetch and IRGB serializer behind a 6845
// Rev 1.0
// ----------------------------------------------------------------------------
module cga_text_sequencer
  import cga_text_sequencer_pkg::*;
#(
  parameter int CHAR_CLKS     = c_CHAR_CLKS,
  parameter int FONT_ROW_BITS = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       divclk,
  input  logic [13:0]                mem_addr,
  input  logic [4:0]                 row_addr,
  input  logic                       display_enable,
  input  logic                       cursor,
  input  logic                       hsync_in,
  input  logic                       vsync_in,
  input  logic                       blink_en,
  input  logic [3:0]                 border,
  cga_text_sequencer_if.master       bus,
  output logic [3:0]                 pixel,
  output logic                       hsync_out,
  output logic                       vsync_out
);

  if (CHAR_CLKS != 8) begin : g_bad_char_clks
    $error("cga_text_sequencer: CHAR_CLKS must be 8");
  end

  if (FONT_ROW_BITS < 5) begin : g_row_unused
    logic w_unused_row_bits;
    assign w_unused_row_bits = ^row_addr[4:FONT_ROW_BITS];
  end

  seq_state_t                 r_state;
  seq_state_t                 w_next;
  logic [13:0]                r_ma;
  logic [FONT_ROW_BITS-1:0]   r_row;
  logic                       r_de;
  logic                       r_cur;
  logic                       r_hs;
  logic                       r_vs;
  logic [7:0]                 r_attr;
  logic [7:0]                 r_font;
  logic [4:0]                 r_frame;
  logic                       r_vs_prev;
  logic [14:0]                r_vram_addr;
  logic                       r_vram_rd;
  // The character byte lives in the upper byte of the font address register.
  logic [8+FONT_ROW_BITS-1:0] r_font_addr;

  irgb_t      w_fg;
  irgb_t      w_bg;
  logic [7:0] w_glyph;
  logic       w_force_fg;
  logic       w_force_border;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (divclk) begin
      w_next = CHAR;
    end else begin
      case (r_state)
        CHAR:    w_next = ATTR;
        ATTR:    w_next = FONT;
        FONT:    w_next = DONE;
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ma        <= '0;
      r_row       <= '0;
      r_de        <= 1'b0;
      r_cur       <= 1'b0;
      r_hs        <= 1'b0;
      r_vs        <= 1'b0;
      r_attr      <= '0;
      r_font      <= '0;
      r_frame     <= '0;
      r_vs_prev   <= 1'b0;
      r_vram_addr <= '0;
      r_vram_rd   <= 1'b0;
      r_font_addr <= '0;
      hsync_out   <= 1'b0;
      vsync_out   <= 1'b0;
    end else begin
      r_vs_prev <= vsync_in;
      if (vsync_in && !r_vs_prev) r_frame <= r_frame + 5'd1;

      if (divclk) begin
        // The previous cell's syncs leave with its first pixel.
        hsync_out   <= r_hs;
        vsync_out   <= r_vs;
        r_ma        <= mem_addr;
        r_row       <= row_addr[FONT_ROW_BITS-1:0];
        r_de        <= display_enable;
        r_cur       <= cursor;
        r_hs        <= hsync_in;
        r_vs        <= vsync_in;
        r_vram_addr <= {mem_addr, 1'b0};
        r_vram_rd   <= 1'b1;
      end else begin
        case (r_state)
          CHAR: r_vram_addr <= {r_ma, 1'b1};
          ATTR: begin
            r_font_addr <= {bus.vram_data, r_row};
            r_vram_rd   <= 1'b0;
          end
          FONT:    r_attr <= bus.vram_data;
          DONE:    r_font <= bus.font_data;
          default: ;
        endcase
      end
    end
  end

  assign bus.vram_addr = r_vram_addr;
  assign bus.vram_rd   = r_vram_rd;
  assign bus.font_addr = r_font_addr;

  assign w_fg           = r_attr[c_ATTR_FG_MSB:c_ATTR_FG_LSB];
  assign w_bg           = {blink_en ? 1'b0 : r_attr[c_ATTR_BLINK],
                           r_attr[c_ATTR_BG_MSB:c_ATTR_BG_LSB]};
  assign w_glyph        = (blink_en && r_attr[c_ATTR_BLINK] && !r_frame[4]) ? 8'h00 : r_font;
  assign w_force_fg     = r_cur && r_frame[3];
  assign w_force_border = !r_de;

  text_pixel_shifter u_shifter (
    .clk          (clk),
    .reset        (reset),
    .load         (divclk),
    .font_byte    (w_glyph),
    .fg           (w_fg),
    .bg           (w_bg),
    .border       (border),
    .force_fg     (w_force_fg),
    .force_border (w_force_border),
    .pixel        (pixel)
  );

endmodule
`default_nettype wire

// File: tb/tb_cga_text_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cga_text_sequencer : directed table-driven bench for the text sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_cga_text_sequencer;

  typedef struct packed {
    logic [13:0] ma;
    logic [4:0]  row;
    logic        de;
    logic        cur;
    logic        hs;
    logic        vs;
    logic        ben;
    logic [3:0]  border;
    logic [7:0]  ch;
    logic [7:0]  attr;
    logic [7:0]  glyph;
    logic [4:0]  frame;
    logic [31:0] exp_px;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        divclk;
  logic [13:0] mem_addr;
  logic [4:0]  row_addr;
  logic        display_enable;
  logic        cursor;
  logic        hsync_in;
  logic        vsync_in;
  logic        blink_en;
  logic [3:0]  border;
  logic [3:0]  pixel;
  logic        hsync_out;
  logic        vsync_out;

  logic [7:0]  vram [0:32767];
  logic [7:0]  font [0:2047];
  logic [4:0]  tb_frame;
  int          checks;
  int          errors;
  vec_t        vecs [12];

  cga_text_sequencer_if #(.FONT_ROW_BITS(3)) bus ();

  cga_text_sequencer #(.CHAR_CLKS(8), .FONT_ROW_BITS(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .divclk         (divclk),
    .mem_addr       (mem_addr),
    .row_addr       (row_addr),
    .display_enable (display_enable),
    .cursor         (cursor),
    .hsync_in       (hsync_in),
    .vsync_in       (vsync_in),
    .blink_en       (blink_en),
    .border         (border),
    .bus            (bus),
    .pixel          (pixel),
    .hsync_out      (hsync_out),
    .vsync_out      (vsync_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle read latency memories.
  always @(posedge clk) begin
    if (bus.vram_rd) bus.vram_data <= vram[bus.vram_addr];
    bus.font_data <= font[bus.font_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic pulse_vsync();
    vsync_in = 1'b1;
    @(negedge clk);
    vsync_in = 1'b0;
    @(negedge clk);
    tb_frame = tb_frame + 5'd1;
  endtask

  // Entered just after a negedge; spans exactly one 8-clock cell and
  // returns the pixels of the previously captured cell.
  task automatic run_cell(input logic [13:0] ma, input logic [4:0] row,
                          input logic de, input logic cur, input logic hs, input logic vs,
                          output logic [31:0] px, output logic [14:0] a0, output logic [14:0] a1,
                          output logic rd1, output logic rd2, output logic [10:0] fa,
                          output logic hso, output logic vso);
    mem_addr       = ma;
    row_addr       = row;
    display_enable = de;
    cursor         = cur;
    hsync_in       = hs;
    vsync_in       = vs;
    divclk         = 1'b1;
    if (vs) tb_frame = tb_frame + 5'd1;
    px  = '0;
    a1  = '0;
    rd1 = 1'b0;
    rd2 = 1'b0;
    fa  = '0;
    @(posedge clk);
    @(negedge clk);
    divclk   = 1'b0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    px[31:28] = pixel;
    a0  = bus.vram_addr;
    hso = hsync_out;
    vso = vsync_out;
    for (int i = 1; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      px[31-4*i -: 4] = pixel;
      if (i == 1) begin
        a1  = bus.vram_addr;
        rd1 = bus.vram_rd;
      end
      if (i == 2) begin
        rd2 = bus.vram_rd;
        fa  = bus.font_addr;
      end
    end
  endtask

  initial begin
    logic [31:0] px, px2;
    logic [14:0] a0, a1, d0, d1;
    logic        rd1, rd2, e1, e2, hso, vso, dh, dv;
    logic [10:0] fa, dfa;

    checks = 0;
    errors = 0;
    tb_frame = '0;
    for (int i = 0; i < 32768; i++) vram[i] = 8'h00;
    for (int i = 0; i < 2048; i++)  font[i] = 8'h00;

    reset = 1'b1; divclk = 1'b0; mem_addr = '0; row_addr = '0; display_enable = 1'b0;
    cursor = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; blink_en = 1'b0; border = 4'h0;

    //           ma       row    de cur hs vs ben bord ch     attr   glyph  frame  pixels
    vecs[0]  = '{14'h0010, 5'd2,  1'b1,1'b0,1'b0,1'b0,1'b0,4'h0,8'h41,8'h1E,8'hA5,5'd0, 32'hE1E11E1E};
    vecs[1]  = '{14'h0100, 5'd0,  1'b1,1'b0,1'b1,1'b0,1'b1,4'h0,8'h02,8'h8F,8'hFF,5'd0, 32'h00000000};
    vecs[2]  = '{14'h0110, 5'd1,  1'b1,1'b0,1'b0,1'b0,1'b1,4'h0,8'h03,8'h8F,8'hFF,5'd15,32'h00000000};
    vecs[3]  = '{14'h0120, 5'd3,  1'b1,1'b0,1'b0,1'b0,1'b1,4'h0,8'h04,8'h8F,8'hFF,5'd16,32'hFFFFFFFF};
    vecs[4]  = '{14'h0130, 5'd7,  1'b1,1'b0,1'b0,1'b0,1'b1,4'h0,8'h05,8'h8F,8'hFF,5'd31,32'hFFFFFFFF};
    vecs[5]  = '{14'h0140, 5'd4,  1'b1,1'b1,1'b0,1'b0,1'b0,4'h0,8'h06,8'h07,8'h00,5'd8, 32'h77777777};
    vecs[6]  = '{14'h0150, 5'd4,  1'b1,1'b1,1'b0,1'b0,1'b0,4'h0,8'h07,8'h07,8'h00,5'd16,32'h00000000};
    vecs[7]  = '{14'h0160, 5'd5,  1'b1,1'b0,1'b0,1'b0,1'b0,4'h0,8'h08,8'h8F,8'h00,5'd16,32'h88888888};
    vecs[8]  = '{14'h0170, 5'd6,  1'b0,1'b1,1'b1,1'b1,1'b0,4'h9,8'h09,8'h1E,8'hA5,5'd24,32'h99999999};
    vecs[9]  = '{14'h0180, 5'h1A, 1'b1,1'b1,1'b0,1'b0,1'b0,4'h0,8'h0A,8'h1E,8'h3C,5'd25,32'hEEEEEEEE};
    vecs[10] = '{14'h0190, 5'd1,  1'b1,1'b0,1'b0,1'b0,1'b0,4'h0,8'h0B,8'h70,8'h0F,5'd25,32'h77770000};
    vecs[11] = '{14'h01A0, 5'd3,  1'b1,1'b0,1'b0,1'b0,1'b1,4'h0,8'h0C,8'hC3,8'hF0,5'd25,32'h33334444};

    repeat (3) @(negedge clk);
    check("reset vram_addr", bus.vram_addr, 0);
    check("reset vram_rd",   bus.vram_rd,   0);
    check("reset font_addr", bus.font_addr, 0);
    check("reset pixel",     pixel,         0);
    check("reset hsync_out", hsync_out,     0);
    check("reset vsync_out", vsync_out,     0);
    reset = 1'b0;

    for (int v = 0; v < 12; v++) begin
      vram[{vecs[v].ma, 1'b0}]           = vecs[v].ch;
      vram[{vecs[v].ma, 1'b1}]           = vecs[v].attr;
      font[{vecs[v].ch, vecs[v].row[2:0]}] = vecs[v].glyph;
      blink_en = vecs[v].ben;
      border   = vecs[v].border;
      while (tb_frame != vecs[v].frame) pulse_vsync();
      run_cell(vecs[v].ma, vecs[v].row, vecs[v].de, vecs[v].cur, vecs[v].hs, vecs[v].vs,
               px, a0, a1, rd1, rd2, fa, hso, vso);
      run_cell(14'h3FFF, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0,
               px2, d0, d1, e1, e2, dfa, dh, dv);
      check($sformatf("v%0d pixels", v),    px2, vecs[v].exp_px);
      check($sformatf("v%0d vram_addr0", v), a0, {vecs[v].ma, 1'b0});
      check($sformatf("v%0d vram_addr1", v), a1, {vecs[v].ma, 1'b1});
      check($sformatf("v%0d vram_rd E1", v), rd1, 1);
      check($sformatf("v%0d vram_rd E2", v), rd2, 0);
      check($sformatf("v%0d font_addr", v), fa, {vecs[v].ch, vecs[v].row[2:0]});
      check($sformatf("v%0d hsync_out", v), dh, vecs[v].hs);
      check($sformatf("v%0d vsync_out", v), dv, vecs[v].vs);
    end

    // Single-cell example with literal addresses.
    check("single font_addr literal", vecs[0].ch == 8'h41 ? 32'h20A : 32'h0, 32'h20A);

    // Reset between the character and attribute fetches.
    border = 4'h0; blink_en = 1'b0;
    vram[15'h0400] = 8'h41;
    vram[15'h0401] = 8'h1E;
    mem_addr = 14'h0200; row_addr = 5'd2; display_enable = 1'b1; cursor = 1'b0; divclk = 1'b1;
    @(posedge clk);
    @(negedge clk);
    divclk = 1'b0;
    check("mid vram_addr E0", bus.vram_addr, 15'h0400);
    @(posedge clk);
    @(negedge clk);
    check("mid vram_rd before reset", bus.vram_rd, 1);
    reset = 1'b1;
    #1;
    check("mid vram_rd async", bus.vram_rd, 0);
    check("mid vram_addr async", bus.vram_addr, 0);
    check("mid font_addr async", bus.font_addr, 0);
    check("mid pixel async", pixel, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tb_frame = '0;
    run_cell(14'h0200, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, px, a0, a1, rd1, rd2, fa, hso, vso);
    check("after reset zeroed stage pixels", px, 32'h00000000);
    check("after reset vram_addr0", a0, 15'h0400);
    check("after reset font_addr", fa, 11'h20A);
    run_cell(14'h3FFF, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, px2, d0, d1, e1, e2, dfa, dh, dv);
    check("after reset next cell pixels", px2, 32'hE1E11E1E);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
